// File: rtl/cvtcolor_og_sdiv_32s_32s_32_seq_if.sv
// rtl/cvtcolor_og_sdiv_32s_32s_32_seq_if.sv - start/ready request and done/result bundle for the signed divider
interface cvtcolor_og_sdiv_32s_32s_32_seq_if #(
  parameter int W = 32
);
  logic         start;
  logic [W-1:0] din0;
  logic [W-1:0] din1;
  logic         ready;
  logic         done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         div_by_zero;

  modport master (
    output start, din0, din1,
    input  ready, done, quot, rem, div_by_zero
  );

  modport slave (
    input  start, din0, din1,
    output ready, done, quot, rem, div_by_zero
  );
endinterface

// File: rtl/cvtcolor_og_sdiv_32s_32s_32_seq.sv
// rtl/cvtcolor_og_sdiv_32s_32s_32_seq.sv - radix-2 restoring signed divider, C truncation semantics
module cvtcolor_og_sdiv_32s_32s_32_seq #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 34,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  cvtcolor_og_sdiv_32s_32s_32_seq_if.slave bus
);

  localparam int W  = din0_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  // Dividend magnitude shifts out MSB-first while quotient bits shift in at the LSB.
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W:0]    dvs_q, dvs_d;
  logic [W:0]    pr_q, pr_d;
  logic          quot_neg_q, quot_neg_d;
  logic          rem_neg_q, rem_neg_d;
  logic          zero_q, zero_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [W:0]    pr_shift;
  logic [W+1:0]  pr_diff;
  logic          pr_ge;
  logic          unused_bits;

  assign pr_shift = {pr_q[W-1:0], dvd_q[W-1]};
  assign pr_diff  = {1'b0, pr_shift} - {1'b0, dvs_q};
  assign pr_ge    = ~pr_diff[W+1];

  // pr never reaches bit W (remainder < divisor <= 2^(W-1)); the config params carry no logic.
  assign unused_bits = ^{pr_q[W], ID[0], NUM_STAGE[0], din1_WIDTH[0], dout_WIDTH[0]};

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    pr_d       = pr_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    zero_d     = zero_q;
    ready_d    = ready_q;
    done_d     = done_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;

    if (ce) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            dvd_d      = bus.din0[W-1] ? -bus.din0 : bus.din0;
            dvs_d      = {1'b0, (bus.din1[W-1] ? -bus.din1 : bus.din1)};
            rem_neg_d  = bus.din0[W-1];
            quot_neg_d = bus.din0[W-1] ^ bus.din1[W-1];
            zero_d     = (bus.din1 == '0);
            pr_d       = '0;
            count_d    = CW'(W);
            ready_d    = 1'b0;
            state_d    = S_CALC;
          end
        end

        S_CALC: begin
          pr_d    = pr_ge ? pr_diff[W:0] : pr_shift;
          dvd_d   = {dvd_q[W-2:0], pr_ge};
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = S_FIX;
          end
        end

        S_FIX: begin
          // With a zero divisor every step subtracts nothing, so pr already equals |din0|.
          quot_d  = zero_q ? '1 : (quot_neg_q ? -dvd_q : dvd_q);
          rem_d   = rem_neg_q ? -pr_q[W-1:0] : pr_q[W-1:0];
          dbz_d   = zero_q;
          done_d  = 1'b1;
          state_d = S_DONE;
        end

        S_DONE: begin
          done_d  = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      pr_q       <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      zero_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      pr_q       <= pr_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      zero_q     <= zero_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.ready       = ready_q;
  assign bus.done        = done_q;
  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule
